l2_line_responder: RTL
======================

Name: l2_line_responder

Overview:
- Responder end of the L1<->L2 line interface. Accepts line read/write requests from the L1 cache and serves them from a word-wide backing memory port.
- Serializes each LINE_W line into BEATS word transactions and collects read beats into a line buffer. Returns a single-cycle line response for reads only.
- Sits between l1_cache and the backing memory or L2 storage model. One request is in service at a time.

Parameters:
ADDR_W, 32, byte address width
LINE_BYTES, 32, bytes per cache line
LINE_W, LINE_BYTES*8, line width in bits
MEM_DATA_W, 32, backing memory word width; LINE_W must be an integer multiple of it

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset; one clock; reset is synchronous and active-high
l2_req_valid  input  1  L1 request valid; held by L1 until accepted
l2_req_ready  output  1  request accepted on the cycle valid&&ready
l2_req_rw  input  1  0=read line, 1=write line
l2_req_addr  input  ADDR_W  byte address; low OFFSET_BITS are forced to 0 internally
l2_req_wline  input  LINE_W  write line data; word k is bits [k*MEM_DATA_W +: MEM_DATA_W]
l2_resp_valid  output  1  one-cycle pulse; read line data is valid
l2_resp_rline  output  LINE_W  read line, registered; holds its value until the next read completes
mem_req  output  1  memory beat request
mem_we  output  1  1=write beat, 0=read beat
mem_addr  output  ADDR_W  beat byte address = line_addr + beat*(MEM_DATA_W/8)
mem_wdata  output  MEM_DATA_W  write beat data
mem_gnt  input  1  beat accepted on the cycle mem_req&&mem_gnt
mem_rvalid  input  1  read data return; in order; may arrive in the same cycle as its grant or later
mem_rdata  input  MEM_DATA_W  read data
proto_err  output  1  sticky flag; set by an unexpected mem_rvalid; cleared only by rst

Behaviour:
- Constants: BEATS=LINE_W/MEM_DATA_W (8 by default); OFFSET_BITS=$clog2(LINE_BYTES).
- Counters: issue_cnt and ret_cnt, each $clog2(BEATS)+1 bits.
- Reset values: state=S_IDLE, counters=0, l2_resp_valid=0, l2_resp_rline=0, proto_err=0.
- While rst=1: l2_req_ready=0 and mem_req=0.
- FSM states: S_IDLE, S_WRITE, S_READ, S_RESP.
- l2_req_ready = (state==S_IDLE) && !rst. It is combinational, with no dependence on l2_req_valid.
- S_IDLE, on valid&&ready:
  - Latch line_addr = {addr[ADDR_W-1:OFFSET_BITS], 0}, rw, and wline.
  - Clear both counters.
  - Go to S_WRITE if rw=1, else S_READ.
- S_WRITE:
  - Outputs: mem_req=1, mem_we=1, mem_addr per issue_cnt, mem_wdata = wline word issue_cnt.
  - Each grant increments issue_cnt.
  - The grant with issue_cnt==BEATS-1 goes to S_IDLE.
  - No l2_resp_valid is produced for writes. L1 proceeds on handshake only.
- S_READ:
  - mem_req = (issue_cnt<BEATS); mem_we=0.
  - Each grant increments issue_cnt.
  - Each mem_rvalid stores mem_rdata into buffer word ret_cnt and increments ret_cnt.
  - The rvalid with ret_cnt==BEATS-1 goes to S_RESP.
  - Grant and rvalid in the same cycle are both counted.
- S_RESP:
  - l2_resp_valid=1 for exactly this cycle; l2_resp_rline = full buffer, with the last beat included.
  - Next state is S_IDLE.
- mem_req deassertion: mem_req never asserts in S_IDLE or S_RESP, and drops the cycle after the last grant.
- Unexpected mem_rvalid sets proto_err and is otherwise ignored (data discarded, no state change). Unexpected means either:
  - rvalid in a state other than S_READ, or
  - rvalid with ret_cnt==issue_cnt (return with no outstanding grant).
- Minimum latency with mem_gnt=1 and zero-latency rvalid (handshake at cycle 0):
  - read: mem beats on cycles 1..8, l2_resp_valid at cycle 9, ready at cycle 10;
  - write: beats on cycles 1..8, ready at cycle 9.
- Back-to-back requests: a writeback followed immediately by a refill is supported. The L1 holds its refill request valid while ready=0; the refill is accepted in the first S_IDLE cycle.
- Request inputs are sampled only at the handshake. Changes to addr or wline afterwards have no effect.
- Reset mid-operation:
  - Any state returns to S_IDLE on the next edge; counters clear; in-flight data is discarded.
  - The backing memory must be reset with the same rst; late returns after reset set proto_err.

Decomposition:
- Package l2_line_pkg holds:
  - typedef state_t {S_IDLE,S_WRITE,S_READ,S_RESP};
  - localparams BEATS_DEF=8 and OFFSET_BITS_DEF=5;
  - rw encoding constants L2_RD=1'b0 and L2_WR=1'b1, shared with l1_cache.
- Single module, no sub-module. The beat buffer is a plain register array inside the module.

Test Plan:
- Read, mem_gnt=1 and zero-latency rvalid, addr 0x0000_1234, memory word i = 0xA000_0000+i:
  - mem_addr runs 0x1220..0x123C;
  - l2_resp_valid high only at cycle 9;
  - rline word k = 0xA000_0000+k.
- Write line word k = 0x5500_0000+k to addr 0x0000_0040:
  - 8 write beats at 0x40..0x5C with matching wdata;
  - l2_resp_valid never asserts; ready returns at cycle 9.
- Writeback to 0x80 immediately followed by a refill request held valid:
  - refill accepted on the first ready cycle;
  - reads start only after the 8th write grant.
- Read with random mem_gnt stalls and rvalid delayed 3 cycles: the line is assembled in order and resp pulses exactly once.
- mem_rvalid injected while in S_IDLE: proto_err=1 and stays set until rst; no resp is issued and state is unchanged.
- rst asserted during the 4th read beat:
  - next cycle state is S_IDLE and mem_req=0;
  - after rst=0, a new read completes correctly with ret data from word 0.

Source files
------------

// File: rtl/l2_line_pkg.sv
// l2_line_pkg: shared types and constants for the L1<->L2 line interface
package l2_line_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;
  localparam int BEATS_DEF = 8;
  localparam int OFFSET_BITS_DEF = 5;
  localparam logic L2_RD = 1'b0;
  localparam logic L2_WR = 1'b1;
endpackage

// File: rtl/l2_line_responder.sv
// l2_line_responder: serves L1 line requests as word beats on a backing memory port
module l2_line_responder
  import l2_line_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_BYTES = 32,
  parameter int LINE_W = LINE_BYTES * 8,
  parameter int MEM_DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  l2_req_valid,
  output logic                  l2_req_ready,
  input  logic                  l2_req_rw,
  input  logic [ADDR_W-1:0]     l2_req_addr,
  input  logic [LINE_W-1:0]     l2_req_wline,
  output logic                  l2_resp_valid,
  output logic [LINE_W-1:0]     l2_resp_rline,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  output logic                  proto_err
);
  localparam int BEATS = LINE_W / MEM_DATA_W;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int IW = $clog2(BEATS);
  localparam int CW = IW + 1;
  localparam int WB = MEM_DATA_W / 8;
  state_t state, state_d;
  logic [CW-1:0] issue_cnt, ret_cnt;
  logic [ADDR_W-1:0] line_addr;
  logic [MEM_DATA_W-1:0] wbuf [BEATS];
  logic [MEM_DATA_W-1:0] rbuf [BEATS];
  logic gnt_fire, rv_ok, last_ret;
  assign l2_req_ready = state == S_IDLE && !rst;
  assign mem_req = !rst && (state == S_WRITE || (state == S_READ && issue_cnt < CW'(BEATS)));
  assign mem_we = state == S_WRITE;
  assign mem_addr = line_addr + ADDR_W'(issue_cnt) * ADDR_W'(WB);
  assign mem_wdata = wbuf[issue_cnt[IW-1:0]];
  assign gnt_fire = mem_req && mem_gnt;
  // a return in the same cycle as its own grant counts as outstanding
  assign rv_ok = mem_rvalid && state == S_READ && (ret_cnt != issue_cnt || gnt_fire);
  assign last_ret = rv_ok && ret_cnt == CW'(BEATS - 1);
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  state_d = l2_req_valid && l2_req_ready ? (l2_req_rw == L2_WR ? S_WRITE : S_READ) : S_IDLE;
      S_WRITE: state_d = gnt_fire && issue_cnt == CW'(BEATS - 1) ? S_IDLE : S_WRITE;
      S_READ:  state_d = last_ret ? S_RESP : S_READ;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      issue_cnt <= '0;
      ret_cnt <= '0;
      l2_resp_valid <= 1'b0;
      l2_resp_rline <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_d;
      l2_resp_valid <= state_d == S_RESP;
      if (mem_rvalid && !rv_ok) proto_err <= 1'b1;
      issue_cnt <= state == S_IDLE ? '0 : issue_cnt + CW'(gnt_fire);
      ret_cnt <= state == S_IDLE ? '0 : ret_cnt + CW'(rv_ok);
      if (last_ret)
        for (int k = 0; k < BEATS; k++)
          l2_resp_rline[k*MEM_DATA_W +: MEM_DATA_W] <= k == BEATS - 1 ? mem_rdata : rbuf[k];
    end
  end
  always_ff @(posedge clk) begin
    if (l2_req_valid && l2_req_ready) begin
      line_addr <= l2_req_addr & ~ADDR_W'((1 << OFFSET_BITS) - 1);
      for (int k = 0; k < BEATS; k++) wbuf[k] <= l2_req_wline[k*MEM_DATA_W +: MEM_DATA_W];
    end
    if (rv_ok) rbuf[ret_cnt[IW-1:0]] <= mem_rdata;
  end
endmodule
